jk_bist: RTL and testbench
==========================

Name: jk_bist

Overview:
- Synthesizable built-in self-test engine for a single JK flip-flop sharing the same clock.
- Drives j/k stimulus to the flop under test and samples the flop's q output.
- Compares q against an internal reference JK model, then reports a mismatch count, the first failing index and pass/fail.
- Sits beside the jk cell on the board top, so the flop can be checked in hardware without a simulator bench.

Parameters:
NUM_VECTORS, 8, number of stimulus vectors applied in RUN (>=1)
START_JK, 2'b00, first {j,k} vector after INIT
CNT_W, 8, width of err_cnt and first_err_idx

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a test
q_i  input  1  q output of the flop under test (same clk)
j_o  output  1  j drive to flop under test (registered)
k_o  output  1  k drive to flop under test (registered)
busy  output  1  high from accepted start until DONE
done  output  1  high in DONE state
pass  output  1  done && err_cnt==0
err_cnt  output  CNT_W  mismatch count, saturating at all-ones
first_err_idx  output  CNT_W  compare index of first mismatch; all-ones if none

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (async, any state, including mid-test):
  - State IDLE.
  - j_o=0, k_o=0, busy=0, done=0, pass=0.
  - err_cnt=0, first_err_idx=all-ones, internal model mq=0.
- States: IDLE -> INIT -> RUN -> FLUSH -> DONE.
  - DONE -> INIT on start.
  - IDLE -> INIT on start.
  - start is ignored in INIT/RUN/FLUSH.
- On an accepted start:
  - Clear err_cnt and set first_err_idx to all-ones.
  - busy=1, done=0.
  - Enter INIT.
- INIT: exactly 2 cycles with j_o=0, k_o=1, which forces the flop to q=0. On exit, mq<=0 and j_o/k_o<=START_JK.
- RUN: exactly NUM_VECTORS cycles.
  - Vector v[n] is driven during RUN cycle n.
  - The next vector is v[n]+1 mod 4 (00->01->10->11->00).
- Model: mq <= JK(mq, j_o, k_o) on every edge from RUN cycle 0 onward, matching the flop's own update.
  - 00 hold, 01 reset, 10 set, 11 toggle.
- Compare:
  - At the end of every RUN cycle and of the FLUSH cycle, compare q_i against mq using pre-edge values.
  - Index 0 checks the INIT result (expected 0).
  - Index i (1..NUM_VECTORS) checks the result of v[i-1].
  - Total compares = NUM_VECTORS+1.
- On a mismatch:
  - err_cnt increments, saturating with no wrap.
  - If first_err_idx is all-ones, it captures the index (also saturating).
- FLUSH: 1 cycle, j_o=0, k_o=0 (hold), final compare.
- DONE:
  - j_o=0, k_o=0, busy=0, done=1.
  - err_cnt and first_err_idx hold until the next accepted start or reset.
- Total latency from start edge to done=1: 2 + NUM_VECTORS + 1 cycles.
- A start asserted on the same edge that enters DONE is ignored. It is accepted only while state is IDLE or DONE.

Optional Feature:
- Macro: JK_BIST_LFSR_EN.
- Defined:
  - Vector source is the low 2 bits of an 8-bit Fibonacci LFSR, taps 8,6,5,4.
  - Seed 8'hA5, loaded on every accepted start; advances one step per RUN cycle.
  - START_JK is unused.
  - All compare/model rules are unchanged.
- Undefined: mod-4 counter sequence as above. No LFSR logic is synthesized.

Test Plan:
- Ideal behavioural JK on q_i, NUM_VECTORS=8, START_JK=00, start pulse -> done after 11 cycles; err_cnt=0, pass=1, first_err_idx=8'hFF; j_o/k_o sequence 01,01,00,01,10,11,00,01,10,11,00.
- q_i stuck at 0, same config -> err_cnt=2, first_err_idx=3, pass=0.
- q_i stuck at 1, same config -> err_cnt=7, first_err_idx=0, pass=0.
- start re-pulsed during RUN cycle 3, then again in DONE -> first pulse ignored with no restart; second pulse clears results, busy=1, second run gives the same results as the first.
- rst_n low for 1 cycle mid-RUN -> immediately busy=0, done=0, j_o=k_o=0, err_cnt=0, first_err_idx=8'hFF, state IDLE; a later start completes normally.
- CNT_W=2, q_i stuck at 1, NUM_VECTORS=8 -> err_cnt saturates at 3, first_err_idx=0. With JK_BIST_LFSR_EN defined and an ideal JK -> pass=1 and the vector sequence matches the LFSR from 8'hA5.

Source files
------------

// File: rtl/jk_bist.sv
// ============================================================================
// Module   : jk_bist
// Purpose  : Built-in self-test engine for one JK flop on the same clock.
//            It drives j/k, checks q against a reference model and reports the results.
// Option   : JK_BIST_LFSR_EN selects LFSR-sourced vectors (seed 8'hA5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_bist #(
  parameter int         NUM_VECTORS = 8,
  parameter logic [1:0] START_JK    = 2'b00,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             q_i,
  output logic             j_o,
  output logic             k_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam int c_nv_w = $clog2(NUM_VECTORS + 1);
  localparam int c_iw   = (c_nv_w >= CNT_W) ? c_nv_w + 1 : CNT_W + 1;
  localparam logic [CNT_W-1:0] c_ones = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state, w_state_nx;
  logic [c_iw-1:0] r_cnt, w_cnt_nx;
  logic [1:0]      r_jk, w_jk_nx;
  logic [1:0]      w_vec_first, w_vec_next;
  logic            w_start_ok, w_cmp_en, r_mq, w_mq_nx;
  logic [CNT_W-1:0] w_sat_idx;

`ifdef JK_BIST_LFSR_EN
  logic [7:0] r_lfsr, w_lfsr_step;
  assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_vec_first = r_lfsr[1:0];
  assign w_vec_next  = w_lfsr_step[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_lfsr <= 8'hA5;
    else if (w_start_ok)       r_lfsr <= 8'hA5;
    else if (r_state == S_RUN) r_lfsr <= w_lfsr_step;
  end
`else
  assign w_vec_first = START_JK;
  assign w_vec_next  = r_jk + 2'd1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_jk    <= 2'b00;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_jk    <= w_jk_nx;
    end
  end

  // The counter keeps running into FLUSH so it doubles as the compare index.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_jk_nx    = r_jk;
    w_start_ok = 1'b0;
    w_cmp_en   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_jk_nx = 2'b00;
        if (start) begin
          w_state_nx = S_INIT;
          w_cnt_nx   = '0;
          w_jk_nx    = 2'b01;
          w_start_ok = 1'b1;
        end
      end
      S_INIT: begin
        w_cnt_nx = r_cnt + c_iw'(1);
        if (r_cnt == c_iw'(1)) begin
          w_state_nx = S_RUN;
          w_cnt_nx   = '0;
          w_jk_nx    = w_vec_first;
        end
      end
      S_RUN: begin
        w_cmp_en = 1'b1;
        w_cnt_nx = r_cnt + c_iw'(1);
        w_jk_nx  = w_vec_next;
        if (r_cnt == c_iw'(NUM_VECTORS - 1)) begin
          w_state_nx = S_FLUSH;
          w_jk_nx    = 2'b00;
        end
      end
      S_FLUSH: begin
        w_cmp_en   = 1'b1;
        w_state_nx = S_DONE;
        w_jk_nx    = 2'b00;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_jk_nx    = 2'b00;
      end
    endcase
  end

  always_comb begin
    case (r_jk)
      2'b00:   w_mq_nx = r_mq;
      2'b01:   w_mq_nx = 1'b0;
      2'b10:   w_mq_nx = 1'b1;
      default: w_mq_nx = ~r_mq;
    endcase
  end

  assign w_sat_idx = (r_cnt >= c_iw'(c_ones)) ? c_ones : r_cnt[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mq          <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= c_ones;
    end else begin
      if (r_state == S_INIT)
        r_mq <= 1'b0;
      else if (w_cmp_en)
        r_mq <= w_mq_nx;

      if (w_start_ok) begin
        err_cnt       <= '0;
        first_err_idx <= c_ones;
      end else if (w_cmp_en && (q_i != r_mq)) begin
        if (err_cnt != c_ones)
          err_cnt <= err_cnt + CNT_W'(1);
        if (first_err_idx == c_ones)
          first_err_idx <= w_sat_idx;
      end
    end
  end

  assign j_o  = r_jk[1];
  assign k_o  = r_jk[0];
  assign busy = (r_state == S_INIT) || (r_state == S_RUN) || (r_state == S_FLUSH);
  assign done = (r_state == S_DONE);
  assign pass = done && (err_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_jk_bist.sv
// ============================================================================
// Module   : tb_jk_bist
// Purpose  : Directed self-checking bench for jk_bist with a behavioural JK flop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_bist;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start_sat = 1'b0;
  logic       q_i, j_o, k_o, busy, done, pass;
  logic [7:0] err_cnt, first_err_idx;
  logic       j_s, k_s, busy_s, done_s, pass_s;
  logic [1:0] err_s, first_s;
  logic       r_ff_q = 1'b0;
  int         mode = 0;  // 0 ideal, 1 stuck-at-0, 2 stuck-at-1
  int         n_chk = 0;
  int         n_err = 0;

`ifdef JK_BIST_LFSR_EN
  // INIT x2, LFSR vectors from 8'hA5, FLUSH
  logic [1:0] seq [11] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10,
                           2'b00, 2'b01, 2'b11, 2'b11, 2'b00};
  localparam int c_s0_err = 4, c_s0_first = 2, c_s1_err = 5, c_s1_first = 0;
`else
  logic [1:0] seq [11] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11,
                           2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
  localparam int c_s0_err = 2, c_s0_first = 3, c_s1_err = 7, c_s1_first = 0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    case ({j_o, k_o})
      2'b01:   r_ff_q <= 1'b0;
      2'b10:   r_ff_q <= 1'b1;
      2'b11:   r_ff_q <= ~r_ff_q;
      default: r_ff_q <= r_ff_q;
    endcase
  end

  assign q_i = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : r_ff_q;

  jk_bist #(.NUM_VECTORS(8), .START_JK(2'b00), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q_i(q_i),
    .j_o(j_o), .k_o(k_o), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  jk_bist #(.NUM_VECTORS(8), .START_JK(2'b00), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_sat), .q_i(1'b1),
    .j_o(j_s), .k_o(k_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_cnt(err_s), .first_err_idx(first_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start a run from IDLE/DONE; restart_at pulses start again during loop cycle i.
  task automatic run_test(input int m, input int exp_err, input int exp_first,
                          input bit chk_seq, input int restart_at);
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_err_clr", 32'(err_cnt), 32'd0);
    check("start_first_clr", 32'(first_err_idx), 32'hFF);
    for (int i = 0; i < 11; i++) begin
      if (chk_seq) check($sformatf("jk_seq%0d", i), 32'({j_o, k_o}), 32'(seq[i]));
      if (busy !== 1'b1) check($sformatf("busy_cyc%0d", i), 32'(busy), 32'd1);
      if (i == restart_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("end_done", 32'(done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_jk", 32'({j_o, k_o}), 32'd0);
    check("end_pass", 32'(pass), 32'(exp_err == 0));
    check("end_err", 32'(err_cnt), 32'(exp_err));
    check("end_first", 32'(first_err_idx), 32'(exp_first));
    @(posedge clk); #1;
    check("hold_done", 32'(done), 32'd1);
    check("hold_err", 32'(err_cnt), 32'(exp_err));
  endtask

  initial begin
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_jk", 32'({j_o, k_o}), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_first", 32'(first_err_idx), 32'hFF);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_test(0, 0, 255, 1'b1, -1);
    // start during RUN cycle 3 must not restart
    run_test(1, c_s0_err, c_s0_first, 1'b0, 5);
    // start on the edge entering DONE is ignored; this run also proves clearing
    run_test(1, c_s0_err, c_s0_first, 1'b0, 10);

    // asynchronous reset mid-RUN
    mode  = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_jk", 32'({j_o, k_o}), 32'd0);
    check("arst_err", 32'(err_cnt), 32'd0);
    check("arst_first", 32'(first_err_idx), 32'hFF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    run_test(2, c_s1_err, c_s1_first, 1'b1, -1);

    // narrow counters saturate
    start_sat = 1'b1;
    @(posedge clk); #1;
    start_sat = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("sat_done", 32'(done_s), 32'd1);
    check("sat_err", 32'(err_s), 32'd3);
    check("sat_first", 32'(first_s), 32'd0);
    check("sat_pass", 32'(pass_s), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
